// File: rtl/mips_trace_packer.sv
// mips_trace_packer: retirement-trace capture for the single-cycle MIPS core.
// Samples {seq, pc, inst, v0} once per retiring edge, buffers the records in a
// small FIFO and serialises each one as a byte packet over valid/ready.
// Records that arrive while the FIFO is full are dropped and counted.
//
// Ports:
//   clk_wb      core write-back clock, one retirement per rising edge
//   rst         asynchronous active-high reset
//   cap_en      capture enable
//   pc_in       core PC
//   inst_in     core current instruction
//   v0_in       core $v0
//   tx_data     stream byte
//   tx_valid    tx_data valid
//   tx_ready    sink accepts the byte
//   fifo_level  records currently buffered
//   overflow    sticky flag, at least one record dropped
//   drop_cnt    dropped-record count, saturating
//   busy        a packet is in flight or records are buffered
//
// Optional feature: define TRACE_CHECKSUM_EN to append an XOR checksum byte
// covering the 14 preceding bytes (header included).
module mips_trace_packer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned LVL_W = 4,
    parameter logic [7:0]  HDR   = 8'hA5
) (
    input  logic             clk_wb,
    input  logic             rst,
    input  logic             cap_en,
    input  logic [31:0]      pc_in,
    input  logic [31:0]      inst_in,
    input  logic [31:0]      v0_in,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [LVL_W-1:0] fifo_level,
    output logic             overflow,
    output logic [15:0]      drop_cnt,
    output logic             busy
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;
    localparam int unsigned REC_W = 104;
`ifdef TRACE_CHECKSUM_EN
    localparam int unsigned NBYTES = 15;
`else
    localparam int unsigned NBYTES = 14;
`endif
    localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [PTR_W-1:0]   level;
    logic [7:0]         seq, seq_nxt;
    logic [REC_W-1:0]   mem [DEPTH];
    logic [REC_W-1:0]   shreg, shreg_nxt;
    logic [3:0]         byte_idx, idx_nxt;
    logic [7:0]         data_nxt;
    logic               valid_nxt, ovf_nxt, busy_nxt;
    logic [15:0]        drop_nxt;
    logic               push, pop, full;
`ifdef TRACE_CHECKSUM_EN
    logic [7:0]         csum, csum_nxt;
`endif

    assign level      = wr_ptr - rd_ptr;
    assign full       = (level == PTR_W'(DEPTH));
    assign fifo_level = LVL_W'(level);

    // Next-state, FIFO control and output logic
    always_comb begin
        state_nxt = state;
        data_nxt  = tx_data;
        valid_nxt = tx_valid;
        shreg_nxt = shreg;
        idx_nxt   = byte_idx;
        seq_nxt   = seq;
        ovf_nxt   = overflow;
        drop_nxt  = drop_cnt;
        push      = 1'b0;
        pop       = 1'b0;
        wr_nxt    = wr_ptr;
        rd_nxt    = rd_ptr;
`ifdef TRACE_CHECKSUM_EN
        csum_nxt  = csum;
`endif

        unique case (state)
            IDLE: begin
                if (level != '0) begin
                    pop       = 1'b1;
                    shreg_nxt = mem[rd_ptr[AW-1:0]];
                    idx_nxt   = 4'd0;
                    data_nxt  = HDR;
                    valid_nxt = 1'b1;
                    state_nxt = SEND;
`ifdef TRACE_CHECKSUM_EN
                    csum_nxt  = 8'h00;
`endif
                end
            end
            SEND: begin
                if (tx_valid && tx_ready) begin
                    if (byte_idx == LAST_IDX) begin
                        valid_nxt = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt   = byte_idx + 4'd1;
                        data_nxt  = shreg[REC_W-1 -: 8];
                        shreg_nxt = {shreg[REC_W-9:0], 8'h00};
`ifdef TRACE_CHECKSUM_EN
                        // Running XOR of every byte already accepted
                        csum_nxt = csum ^ tx_data;
                        if (byte_idx == LAST_IDX - 4'd1) begin
                            data_nxt = csum_nxt;
                        end
`endif
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A full FIFO still accepts when the same edge pops the head
        if (cap_en) begin
            seq_nxt = seq + 8'd1;
            if (!full || pop) begin
                push = 1'b1;
            end else begin
                ovf_nxt = 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_nxt = drop_cnt + 16'd1;
                end
            end
        end

        if (push) wr_nxt = wr_ptr + PTR_W'(1);
        if (pop)  rd_nxt = rd_ptr + PTR_W'(1);

        busy_nxt = (state_nxt == SEND) || (wr_nxt != rd_nxt);
    end

    // State and output registers
    always_ff @(posedge clk_wb or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            seq      <= 8'h00;
            shreg    <= '0;
            byte_idx <= 4'd0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            overflow <= 1'b0;
            drop_cnt <= 16'h0000;
            busy     <= 1'b0;
`ifdef TRACE_CHECKSUM_EN
            csum     <= 8'h00;
`endif
        end else begin
            state    <= state_nxt;
            wr_ptr   <= wr_nxt;
            rd_ptr   <= rd_nxt;
            seq      <= seq_nxt;
            shreg    <= shreg_nxt;
            byte_idx <= idx_nxt;
            tx_data  <= data_nxt;
            tx_valid <= valid_nxt;
            overflow <= ovf_nxt;
            drop_cnt <= drop_nxt;
            busy     <= busy_nxt;
`ifdef TRACE_CHECKSUM_EN
            csum     <= csum_nxt;
`endif
        end
    end

    // Record storage; contents are don't-care until written
    always_ff @(posedge clk_wb) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {seq, pc_in, inst_in, v0_in};
        end
    end

endmodule

// File: tb/tb_mips_trace_packer.sv
// Self-checking bench for mips_trace_packer: directed scenarios plus random
// capture/back-pressure traffic, checked against a queue-level model.
module tb_mips_trace_packer;

    localparam int unsigned DEPTH = 8;
    localparam logic [7:0]  HDR   = 8'hA5;
`ifdef TRACE_CHECKSUM_EN
    localparam int NB = 15;
`else
    localparam int NB = 14;
`endif

    logic        clk_wb = 1'b0;
    logic        rst    = 1'b1;
    logic        cap_en = 1'b0;
    logic [31:0] pc_in = '0, inst_in = '0, v0_in = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic        busy;

    mips_trace_packer dut (
        .clk_wb     (clk_wb),
        .rst        (rst),
        .cap_en     (cap_en),
        .pc_in      (pc_in),
        .inst_in    (inst_in),
        .v0_in      (v0_in),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .busy       (busy)
    );

    always #5 clk_wb = ~clk_wb;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [103:0] mq[$];
    logic [7:0]   exp_q[$];
    logic [7:0]   log_q[$];
    bit           m_tx   = 0;
    int           m_left = 0;
    int           pkt_hs = 0;
    logic [7:0]   m_seq  = 0;
    int           m_drop = 0;
    bit           m_ovf  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_bytes(input logic [103:0] r);
        logic [7:0] b, x;
        x = HDR;
        exp_q.push_back(HDR);
        for (int i = 0; i < 13; i++) begin
            b = r[103 - 8*i -: 8];
            exp_q.push_back(b);
            x = x ^ b;
        end
`ifdef TRACE_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    // Model: predicts the upcoming edge from inputs stable at negedge
    always @(negedge clk_wb) begin
        logic [103:0] r;
        bit pop, acc;
        if (rst) begin
            chk("rst_tx_valid", 32'(tx_valid), 0);
            chk("rst_tx_data", 32'(tx_data), 0);
            chk("rst_fifo_level", 32'(fifo_level), 0);
            chk("rst_overflow", 32'(overflow), 0);
            chk("rst_drop_cnt", 32'(drop_cnt), 0);
            chk("rst_busy", 32'(busy), 0);
            mq.delete();
            exp_q.delete();
            m_tx = 0; m_left = 0; pkt_hs = 0; m_seq = 0; m_drop = 0; m_ovf = 0;
        end else begin
            chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            chk("busy", 32'(busy), 32'(m_tx || mq.size() > 0));
            chk("tx_valid", 32'(tx_valid), 32'(m_tx));
            pop = !m_tx && mq.size() > 0;
            acc = (mq.size() < DEPTH) || pop;
            if (m_tx && tx_ready) begin
                pkt_hs++;
                m_left--;
                if (m_left == 0) m_tx = 0;
            end
            if (pop) begin
                r = mq.pop_front();
                push_bytes(r);
                m_tx = 1; m_left = NB; pkt_hs = 0;
            end
            if (cap_en) begin
                if (acc) mq.push_back({m_seq, pc_in, inst_in, v0_in});
                else begin
                    m_ovf = 1;
                    if (m_drop < 65535) m_drop++;
                end
                m_seq = m_seq + 8'd1;
            end
        end
    end

    // Monitor: compares every accepted byte against the scoreboard
    logic       pv = 0, pr = 0;
    logic [7:0] pd = 0;
    always @(negedge clk_wb) begin
        logic [7:0] e;
        if (rst) begin
            pv = 0;
        end else begin
            if (pv && !pr && tx_valid) chk("hold_data", 32'(tx_data), 32'(pd));
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte: got %h expected none at %0t", tx_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte", 32'(tx_data), 32'(e));
                end
                log_q.push_back(tx_data);
            end
            pv = tx_valid; pr = tx_ready; pd = tx_data;
        end
    end

    task automatic step(input logic cap, input logic rdy);
        cap_en   = cap;
        tx_ready = rdy;
        @(posedge clk_wb);
        #1;
    endtask

    task automatic rand_data();
        pc_in   = $urandom;
        inst_in = $urandom;
        v0_in   = $urandom;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, 0);
        step(0, 0);
        rst = 1'b0;
        step(0, 0);
    endtask

    task automatic drain(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            step(0, 1);
            done = (mq.size() == 0) && !m_tx && (exp_q.size() == 0);
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s: drain timed out, %0d bytes outstanding", name, exp_q.size());
        end
    endtask

    initial begin
        logic [7:0] t1 [14];
        bit found;
        int d0;
        t1 = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h24,
               8'h02, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        @(posedge clk_wb);
        #1;

        // Reset then single capture
        do_reset();
        log_q.delete();
        pc_in = 32'h0000_0040; inst_in = 32'h2402_0005; v0_in = 32'h0;
        step(1, 1);
        drain("t1");
        chk("t1_len", 32'(log_q.size()), 32'(NB));
        for (int i = 0; i < 14; i++)
            if (i < log_q.size()) chk("t1_byte", 32'(log_q[i]), 32'(t1[i]));

        // Back-pressure: tx_ready toggles every cycle
        rand_data();
        step(1, 0);
        for (int i = 0; i < 40; i++) step(0, logic'(i % 2));
        drain("t2");

        // Overflow with the sink stalled
        do_reset();
        for (int i = 0; i < 12; i++) begin
            rand_data();
            step(1, 0);
        end
        cap_en = 0;
        @(negedge clk_wb);
        chk("t3_level", 32'(fifo_level), 8);
        chk("t3_drop", 32'(drop_cnt), 3);
        chk("t3_ovf", 32'(overflow), 1);

        // Full FIFO: push lands on the IDLE pop edge
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(0, 1);
            found = !m_tx && mq.size() > 0;
        end
        chk("t4_reached_pop", 32'(found), 1);
        rand_data();
        step(1, 1);
        cap_en = 0;
        @(negedge clk_wb);
        chk("t4_level", 32'(fifo_level), 8);
        chk("t4_drop", 32'(drop_cnt), 3);
        drain("t3_t4");

        // Mid-packet reset after byte 5 is accepted
        do_reset();
        rand_data();
        step(1, 1);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(0, 1);
            found = m_tx && pkt_hs == 5;
        end
        chk("t5_reached_byte5", 32'(found), 1);
        rst = 1'b1;
        #1;
        chk("t5_valid_async", 32'(tx_valid), 0);
        @(negedge clk_wb);
        chk("t5_busy", 32'(busy), 0);
        step(0, 1);
        rst = 1'b0;
        step(0, 1);
        log_q.delete();
        rand_data();
        step(1, 1);
        drain("t5");
        if (log_q.size() > 1) chk("t5_seq0", 32'(log_q[1]), 0);
        else chk("t5_len", 32'(log_q.size()), 32'(NB));

        // Sequence wrap: 257 spaced captures, no drops
        d0 = int'(drop_cnt);
        for (int n = 0; n < 257; n++) begin
            rand_data();
            step(1, 1);
            for (int i = 0; i < 15; i++) step(0, 1);
        end
        drain("t6");
        chk("t6_no_drop", 32'(drop_cnt), 32'(d0));

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            rand_data();
            step(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 9) < 7));
        end
        drain("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
